// File: rtl/jtkicker_objdraw_if.sv
// Object ROM fetch handshake between the object drawer and the SDRAM arbiter.
// The drawer holds rom_addr stable while rom_cs is high until rom_ok arrives.
interface jtkicker_objdraw_if;
    logic [12:0] rom_addr;
    logic        rom_cs;
    logic [31:0] rom_data;
    logic        rom_ok;

    modport master (output rom_addr, rom_cs, input rom_data, rom_ok);
    modport slave  (input rom_addr, rom_cs, output rom_data, rom_ok);
endinterface

// File: rtl/jtkicker_objdraw.sv
// Object pixel drawer: fetches one 16-pixel sprite row, maps it through the palette PROM
// into a double line buffer and plays the buffer back on the following line.
module jtkicker_objdraw #(
    parameter logic [7:0] HOFFSET = 8'd0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pxl_cen,
    input  logic                      LHBL,
    input  logic [8:0]                hdump,
    input  logic                      draw,
    input  logic [7:0]                code,
    input  logic [3:0]                ysub,
    input  logic                      vflip,
    input  logic                      hflip,
    input  logic [3:0]                pal,
    input  logic [8:0]                hpos,
    output logic                      busy,
    jtkicker_objdraw_if.master        rom,
    input  logic [7:0]                prog_addr,
    input  logic [3:0]                prog_data,
    input  logic                      prog_en,
    output logic [3:0]                pxl
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAW} state_t;

    state_t      state;
    logic [7:0]  code_l;
    logic [3:0]  ysub_l;
    logic        vflip_l, hflip_l;
    logic [3:0]  pal_l;
    logic [8:0]  hpos_l;
    logic        half, word_idx;
    logic [2:0]  cnt;
    logic [31:0] data_l;

    logic [3:0]  prom [256];
    logic [3:0]  prom_q;
    logic [3:0]  buf0 [256];
    logic [3:0]  buf1 [256];

    logic        wsel, lhbl_l, swap, play, wr_v, wr_en;
    logic [8:0]  wr_x;
    logic [4:0]  nib_lsb;
    logic [3:0]  nib;
    logic [7:0]  rd_a;
    logic        unused_hdump;

    assign unused_hdump = hdump[8];
    assign swap    = lhbl_l & ~LHBL;
    assign play    = pxl_cen & LHBL & ~rst;
    assign rd_a    = hdump[7:0] + HOFFSET;
    // pixel 0 sits in the top nibble, so the unflipped shift is 4*(7-cnt)
    assign nib_lsb = hflip_l ? {cnt, 2'b00} : {~cnt, 2'b00};
    assign nib     = data_l[nib_lsb +: 4];
    assign wr_en   = wr_v & ~wr_x[8] & (prom_q != 4'd0) & ~(swap & busy) & ~rst;

    always_ff @(posedge clk) begin
        if (prog_en) prom[prog_addr] <= prog_data;
        prom_q <= prom[{pal_l, nib}];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            rom.rom_cs   <= 1'b0;
            rom.rom_addr <= 13'd0;
            code_l       <= 8'd0;
            ysub_l       <= 4'd0;
            vflip_l      <= 1'b0;
            hflip_l      <= 1'b0;
            pal_l        <= 4'd0;
            hpos_l       <= 9'd0;
            half         <= 1'b0;
            word_idx     <= 1'b0;
            cnt          <= 3'd0;
            data_l       <= 32'd0;
            wr_v         <= 1'b0;
            wr_x         <= 9'd0;
        end else begin
            wr_v <= 1'b0;
            if (swap) begin
                // line change: abandon whatever sprite is in flight
                state      <= IDLE;
                busy       <= 1'b0;
                rom.rom_cs <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (draw) begin
                        code_l       <= code;
                        ysub_l       <= ysub;
                        vflip_l      <= vflip;
                        hflip_l      <= hflip;
                        pal_l        <= pal;
                        hpos_l       <= hpos;
                        half         <= hflip;
                        word_idx     <= 1'b0;
                        rom.rom_addr <= {code, ysub ^ {4{vflip}}, hflip};
                        busy         <= 1'b1;
                        rom.rom_cs   <= 1'b1;
                        state        <= FETCH;
                    end
                    FETCH: if (rom.rom_ok) begin
                        data_l     <= rom.rom_data;
                        cnt        <= 3'd0;
                        rom.rom_cs <= 1'b0;
                        state      <= DRAW;
                    end
                    DRAW: begin
                        wr_v <= 1'b1;
                        wr_x <= hpos_l + {5'd0, word_idx, cnt};
                        cnt  <= cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            if (!word_idx) begin
                                word_idx     <= 1'b1;
                                half         <= ~half;
                                rom.rom_addr <= {code_l, ysub_l ^ {4{vflip_l}}, ~half};
                                rom.rom_cs   <= 1'b1;
                                state        <= FETCH;
                            end else begin
                                busy  <= 1'b0;
                                state <= IDLE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wsel   <= 1'b0;
            lhbl_l <= 1'b0;
            pxl    <= 4'd0;
        end else begin
            lhbl_l <= LHBL;
            if (swap) wsel <= ~wsel;
            if (!LHBL)        pxl <= 4'd0;
            else if (pxl_cen) pxl <= wsel ? buf0[rd_a] : buf1[rd_a];
        end
    end

    // each bank has one write port: drawing into the write bank, clear-on-read in the other
    always_ff @(posedge clk) begin
        if (wr_en && !wsel)     buf0[wr_x[7:0]] <= prom_q;
        else if (play && wsel)  buf0[rd_a]      <= 4'd0;
        if (wr_en && wsel)      buf1[wr_x[7:0]] <= prom_q;
        else if (play && !wsel) buf1[rd_a]      <= 4'd0;
    end
endmodule

// File: tb/tb_jtkicker_objdraw.sv
// Bench for jtkicker_objdraw: random sprites against a per-pixel line model,
// plus directed flip, overlap, clip, handshake, abort and reset cases.
module tb_jtkicker_objdraw;
    logic       clk = 1'b0, rst = 1'b1, pxl_cen = 1'b0, LHBL = 1'b1;
    logic [8:0] hdump = 9'd0, hpos = 9'd0;
    logic       draw = 1'b0, vflip = 1'b0, hflip = 1'b0, prog_en = 1'b0;
    logic [7:0] code = 8'd0, prog_addr = 8'd0;
    logic [3:0] ysub = 4'd0, pal = 4'd0, prog_data = 4'd0;
    logic       busy;
    logic [3:0] pxl;

    jtkicker_objdraw_if rom_if();

    jtkicker_objdraw dut (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .LHBL(LHBL), .hdump(hdump),
        .draw(draw), .code(code), .ysub(ysub), .vflip(vflip), .hflip(hflip),
        .pal(pal), .hpos(hpos), .busy(busy), .rom(rom_if),
        .prog_addr(prog_addr), .prog_data(prog_data), .prog_en(prog_en), .pxl(pxl)
    );

    always #10 clk = ~clk;

    int          n_vec = 0, n_err = 0;
    logic [31:0] rom_mem [8192];
    logic [3:0]  prom_m [256];
    logic [3:0]  line_m [256];
    logic [3:0]  play_m [256];
    logic [3:0]  seen [256];
    int          rom_delay = 0;
    int          wcnt = 0;
    logic [12:0] fetch_addr;
    logic [12:0] served_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // SDRAM model: answers rom_delay clocks after a request, checks the address holds
    always @(negedge clk) begin
        if (rom_if.rom_cs) begin
            if (wcnt == 0) fetch_addr = rom_if.rom_addr;
            else chk("rom_addr_stable", rom_if.rom_addr, fetch_addr);
            if (wcnt >= rom_delay) begin
                rom_if.rom_ok   = 1'b1;
                rom_if.rom_data = rom_mem[rom_if.rom_addr];
                served_q.push_back(rom_if.rom_addr);
            end else rom_if.rom_ok = 1'b0;
            wcnt++;
        end else begin
            rom_if.rom_ok = 1'b0;
            wcnt = 0;
        end
    end

    function automatic logic [12:0] rom_a(logic [7:0] c, logic [3:0] ys, logic vf, logic hf, int w);
        logic wb = w[0];
        return {c, ys ^ {4{vf}}, hf ^ wb};
    endfunction

    // paint the first npix pixels of a sprite row into the line being drawn
    function automatic void model_sprite(logic [7:0] c, logic [3:0] ys, logic vf, logic hf,
                                         logic [3:0] pl, logic [8:0] hp, int npix);
        for (int p = 0; p < npix; p++) begin
            int          w = p / 8, cc = p % 8, k, x;
            logic [31:0] sh;
            logic [3:0]  col;
            k   = hf ? 7 - cc : cc;
            sh  = rom_mem[rom_a(c, ys, vf, hf, w)] >> (28 - 4 * k);
            col = prom_m[{pl, sh[3:0]}];
            x   = (int'(hp) + p) % 512;
            if (x < 256 && col != 4'd0) line_m[x] = col;
        end
    endfunction

    task automatic draw_sprite(input logic [7:0] c, input logic [3:0] ys, input logic vf,
                               input logic hf, input logic [3:0] pl, input logic [8:0] hp,
                               input int d, input int extra_at);
        int nb = 0;
        rom_delay = d;
        served_q.delete();
        code = c; ysub = ys; vflip = vf; hflip = hf; pal = pl; hpos = hp; draw = 1'b1;
        @(negedge clk);
        draw = 1'b0;
        while (busy && nb < 200) begin
            if (nb == extra_at) begin
                draw = 1'b1; code = ~c; hpos = hp + 9'd37; hflip = ~hf; pal = pl + 4'd1;
            end else draw = 1'b0;
            nb++;
            @(negedge clk);
        end
        draw = 1'b0;
        chk("busy_len", nb, 2 * (d + 1) + 16);
        chk("fetch_count", served_q.size(), 2);
        if (served_q.size() == 2) begin
            chk("rom_addr_w0", served_q[0], rom_a(c, ys, vf, hf, 0));
            chk("rom_addr_w1", served_q[1], rom_a(c, ys, vf, hf, 1));
        end
        model_sprite(c, ys, vf, hf, pl, hp, 16);
    endtask

    task automatic draw_rand(input int hp);
        logic [8:0] h = (hp < 0) ? 9'($urandom_range(0, 511)) : 9'(hp);
        draw_sprite(8'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
                    h, $urandom_range(0, 3), -1);
    endtask

    function automatic void swap_model();
        for (int i = 0; i < 256; i++) begin
            play_m[i] = line_m[i];
            line_m[i] = 4'd0;
        end
    endfunction

    task automatic do_swap(input bit with_draw);
        @(negedge clk);
        LHBL = 1'b0;
        if (with_draw) begin
            code = 8'($urandom); hpos = 9'($urandom_range(0, 200)); draw = 1'b1;
        end
        @(negedge clk);
        draw = 1'b0;
        chk("busy_after_swap", busy, 0);
        chk("pxl_blank", pxl, 0);
        swap_model();
    endtask

    task automatic play_line(input string tag, input bit check);
        LHBL = 1'b1;
        @(negedge clk);
        @(negedge clk);
        for (int h = 0; h < 256; h++) begin
            hdump = 9'(h); pxl_cen = 1'b1;
            @(negedge clk);
            seen[h] = pxl;
            if (check) chk(tag, pxl, play_m[h]);
        end
        pxl_cen = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] exp_b;
        int          j, nb;
        for (int i = 0; i < 256; i++) begin line_m[i] = 4'd0; play_m[i] = 4'd0; end
        for (int i = 0; i < 8192; i++) rom_mem[i] = $urandom;
        for (int i = 0; i < 256; i++)
            prom_m[i] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        for (int n = 0; n < 16; n++) prom_m[{4'h2, 4'(n)}] = 4'(n);

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_rom_cs", rom_if.rom_cs, 0);
        chk("rst_rom_addr", rom_if.rom_addr, 0);
        chk("rst_pxl", pxl, 0);
        rst = 1'b0;

        for (int i = 0; i < 256; i++) begin
            prog_en = 1'b1; prog_addr = 8'(i); prog_data = prom_m[i];
            @(negedge clk);
        end
        prog_en = 1'b0;

        // flush both banks, whose power-up contents are unknown
        do_swap(0); play_line("flush", 0);
        do_swap(0); play_line("flush", 0);

        // basic draw
        rom_mem[13'h0A6] = 32'h1234_5678;
        rom_mem[13'h0A7] = 32'h9ABC_DEF0;
        draw_sprite(8'h05, 4'd3, 1'b0, 1'b0, 4'd2, 9'd16, 1, -1);
        do_swap(0); play_line("basic_line", 1);
        exp_b = 64'h1234_5678_9ABC_DEF0;
        for (int i = 0; i < 16; i++) chk("basic_x", seen[16 + i], exp_b[63 - 4 * i -: 4]);

        // hflip with the same words
        draw_sprite(8'h05, 4'd3, 1'b0, 1'b1, 4'd2, 9'd16, 0, -1);
        do_swap(0); play_line("hflip_line", 1);
        exp_b = 64'h0FED_CBA9_8765_4321;
        for (int i = 0; i < 16; i++) chk("hflip_x", seen[16 + i], exp_b[63 - 4 * i -: 4]);

        // transparency and overlap
        rom_mem[rom_a(8'h10, 4'd0, 1'b0, 1'b0, 0)] = 32'h3333_3333;
        rom_mem[rom_a(8'h10, 4'd0, 1'b0, 1'b0, 1)] = 32'h3333_3333;
        rom_mem[rom_a(8'h11, 4'd0, 1'b0, 1'b0, 0)] = 32'h5050_5050;
        rom_mem[rom_a(8'h11, 4'd0, 1'b0, 1'b0, 1)] = 32'h5050_5050;
        draw_sprite(8'h10, 4'd0, 1'b0, 1'b0, 4'd2, 9'd100, 2, -1);
        draw_sprite(8'h11, 4'd0, 1'b0, 1'b0, 4'd2, 9'd100, 0, -1);
        do_swap(0); play_line("overlap_line", 1);
        for (int i = 0; i < 16; i++) chk("overlap_x", seen[100 + i], (i % 2 == 0) ? 5 : 3);

        // right-edge clip and fully off-screen position
        draw_rand(250);
        draw_rand(9'h1F0);
        do_swap(0); play_line("clip_line", 1);
        for (int i = 0; i < 10; i++) chk("clip_x0", seen[i], 0);

        // slow ROM with a second draw pulse during the fetch
        draw_sprite(8'($urandom), 4'($urandom), 1'b1, 1'b0, 4'($urandom), 9'd60, 7, 3);
        do_swap(0); play_line("handshake_line", 1);

        // random lines
        for (int l = 0; l < 6; l++) begin
            for (int s = 0; s < 4; s++) draw_rand(-1);
            do_swap(0); play_line("rand_line", 1);
        end

        // abort: line falls while a sprite is mid-draw
        draw_rand(9'($urandom_range(0, 120)));
        j = $urandom_range(0, 7);
        rom_delay = 0; served_q.delete();
        code = 8'($urandom); ysub = 4'($urandom); vflip = 1'b0; hflip = 1'($urandom);
        pal = 4'($urandom); hpos = 9'd180; draw = 1'b1;
        @(negedge clk);
        draw = 1'b0;
        nb = 0;
        while (!(busy && !rom_if.rom_cs) && nb < 50) begin nb++; @(negedge clk); end
        chk("abort_reach_draw", (nb < 50) ? 1 : 0, 1);
        repeat (j) @(negedge clk);
        LHBL = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_rom_cs", rom_if.rom_cs, 0);
        chk("abort_fetches", served_q.size(), 1);
        model_sprite(code, ysub, vflip, hflip, pal, hpos, (j > 1) ? j - 1 : 0);
        swap_model();
        play_line("abort_line", 1);
        // both banks read back empty, including the one just played
        do_swap(1); play_line("empty_line", 1);
        do_swap(0); play_line("cleared_line", 1);

        // reset in the middle of a fetch
        rom_delay = 20;
        code = 8'($urandom); hpos = 9'd30; draw = 1'b1;
        @(negedge clk);
        draw = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_rom_cs", rom_if.rom_cs, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_rom_cs", rom_if.rom_cs, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rom_addr", rom_if.rom_addr, 0);
        rst = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 3; s++) draw_rand(-1);
        do_swap(0); play_line("post_rst_line", 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
